// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF/ID pipeline latch with stall, flush, redirect and misaligned-trap handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        exc_misaligned,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d;
  logic        valid_q, valid_d, exc_q, exc_d;
  logic        run, misal, hold, fetch;
  always_comb begin
    run     = state_q == RUN;
    misal   = run && redirect_valid && |redirect_target[1:0];
    hold    = run && !redirect_valid && stall && !flush;
    fetch   = run && !redirect_valid && !stall && !flush;
    state_d = misal ? TRAP : RUN;
    pc_d    = !run ? pc_q
            : redirect_valid ? (misal ? EXC_VECTOR : redirect_target)
            : stall ? pc_q : pc_q + 32'd4;
    // Anything that is neither a fresh fetch nor a held entry becomes a bubble.
    instr_d = fetch ? imem_instr : hold ? instr_q : 32'h0;
    pc4_d   = fetch ? pc_q + 32'd4 : hold ? pc4_q : 32'h0;
    valid_d = fetch | (hold & valid_q);
    exc_d   = misal;
    cnt_d   = cnt_q + {31'b0, fetch};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign exc_misaligned = exc_q;
  assign fetch_count    = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a cycle-level behavioural model.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0180;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0, imem_addr, imem_instr, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, exc_misaligned;
  logic [31:0] mpc, minstr, mpc4, mcnt;
  logic        mvalid, mexc;
  int          mdead, n_checks = 0, n_fail = 0;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .exc_misaligned(exc_misaligned),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2012_000a;
    if (a == 32'h0040_0004) return 32'h2013_000a;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  assign imem_instr = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    minstr = 32'h0; mpc4 = 32'h0; mvalid = 1'b0;
  endtask

  task automatic model_reset();
    mpc = RST_PC; mcnt = 32'h0; mexc = 1'b0; mdead = 1; bubble();
  endtask

  // One clock edge of the fetch stage, from the rules: settle cycles, redirect, stall, normal.
  task automatic model_edge();
    mexc = 1'b0;
    if (mdead > 0) begin
      mdead--; bubble();
    end else if (redirect_valid) begin
      bubble();
      if (redirect_target[1:0] != 2'b00) begin
        mpc = EXC_PC; mexc = 1'b1; mdead = 1;
      end else mpc = redirect_target;
    end else if (stall) begin
      if (flush) bubble();
    end else begin
      if (flush) bubble();
      else begin
        minstr = mem(mpc); mpc4 = mpc + 32'd4; mvalid = 1'b1; mcnt = mcnt + 32'd1;
      end
      mpc = mpc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("imem_addr", imem_addr, mpc);
    chk("if_id_instr", if_id_instr, minstr);
    chk("if_id_pc_plus4", if_id_pc_plus4, mpc4);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, mvalid});
    chk("exc_misaligned", {31'b0, exc_misaligned}, {31'b0, mexc});
    chk("fetch_count", fetch_count, mcnt);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rt);
    stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
  endtask

  // Asynchronous pulse placed between edges; outputs must reset before the next edge.
  task automatic async_reset_pulse();
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;
    step();
    chk("boot_bubble", {31'b0, if_id_valid}, 32'h0);
    step();
    chk("first_instr", if_id_instr, 32'h2012_000a);
    chk("first_pc4", if_id_pc_plus4, 32'h0040_0004);
    step();
    chk("second_instr", if_id_instr, 32'h2013_000a);
    chk("second_pc4", if_id_pc_plus4, 32'h0040_0008);
    chk("count_two", fetch_count, 32'd2);
    step();
    step();
    chk("pc_before_stall", imem_addr, 32'h0040_0010);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      step();
      chk("stall_pc", imem_addr, 32'h0040_0010);
      chk("stall_count", fetch_count, 32'd4);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("resume_pc", imem_addr, 32'h0040_0014);
    chk("resume_pc4", if_id_pc_plus4, 32'h0040_0014);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("stall_flush_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h0040_0098);
    step();
    chk("redir_pc", imem_addr, 32'h0040_0098);
    chk("redir_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("redir_pc4", if_id_pc_plus4, 32'h0040_009C);
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0102);
    step();
    chk("misal_pc", imem_addr, EXC_PC);
    chk("misal_exc", {31'b0, exc_misaligned}, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1000);
    step();
    chk("trap_exc_clear", {31'b0, exc_misaligned}, 32'h0);
    chk("trap_pc_hold", imem_addr, EXC_PC);
    chk("trap_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("trap_fetch_pc4", if_id_pc_plus4, 32'h0040_0184);
    chk("trap_fetch_valid", {31'b0, if_id_valid}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_valid", {31'b0, if_id_valid}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0200);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0300);
    step();
    chk("b2b_redir", imem_addr, 32'h0040_0300);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("flush_pc_adv", imem_addr, 32'h0040_0304);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = 32'h0040_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      drive($urandom_range(3) == 0, $urandom_range(6) == 0, $urandom_range(9) == 0, t);
      if ($urandom_range(63) == 0) async_reset_pulse();
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0001);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    async_reset_pulse();
    chk("trap_reset_pc", imem_addr, RST_PC);
    chk("trap_reset_exc", {31'b0, exc_misaligned}, 32'h0);
    step();
    chk("post_reset_exc", {31'b0, exc_misaligned}, 32'h0);
    step();
    chk("post_reset_fetch", if_id_pc_plus4, 32'h0040_0004);
    chk("post_reset_instr", if_id_instr, 32'h2012_000a);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
